// File: rtl/ibm_clock_ring_gen.sv
// ibm_clock_ring_gen
//   Behavioural clock ring for the 1620-style memory/core timing chain.
//   A prescaler divides SYSCLOCK by DIV. Each prescaler terminal count steps
//   a RING_LEN-position one-hot ring (position 0 = C1). Each wrap toggles the
//   A/B advance trigger, bumps a completed-cycle counter and emits one-clock
//   cycle_end and a_advance/b_advance pulses.
//
//   Optional build macro: IBM_CLOCK_RING_STEP_EN
//     defined   - step_i advances a stopped ring by one position per clock
//     undefined - step_i is ignored and a stopped ring always rests at C1
//
// Ports
//   SYSCLOCK_i        system clock, rising edge
//   RESET_i           synchronous active-high reset
//   run_i             level, free-run request
//   single_cycle_i    pulse, run exactly one ring cycle from STOPPED
//   step_i            pulse, manual advance while stopped (optional feature)
//   ring_o            one-hot ring, bit i = C(i+1)
//   pos_o             binary ring position
//   tick_o            high when the closing edge of this cycle advances the ring
//   cycle_end_o       one-clock pulse after each wrap
//   a_advance_o       one-clock pulse after wraps that set ab_trigger
//   b_advance_o       one-clock pulse after wraps that clear ab_trigger
//   ab_trigger_o      toggles on every wrap
//   busy_o            high whenever the ring is not stopped
//   cycle_count_o     completed ring cycles, modulo 2^CNT_W
//
// States
//   ST_STOPPED | ring parked, prescaler held at 0
//   ST_RUN     | free running while run_i is high
//   ST_DRAIN   | run_i dropped mid-cycle, stepping on to the next wrap
//   ST_SINGLE  | one full ring cycle requested by single_cycle_i

module ibm_clock_ring_gen #(
  parameter int RING_LEN = 10,
  parameter int DIV      = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        SYSCLOCK_i,
  input  logic                        RESET_i,
  input  logic                        run_i,
  input  logic                        single_cycle_i,
  input  logic                        step_i,
  output logic [RING_LEN-1:0]         ring_o,
  output logic [$clog2(RING_LEN)-1:0] pos_o,
  output logic                        tick_o,
  output logic                        cycle_end_o,
  output logic                        a_advance_o,
  output logic                        b_advance_o,
  output logic                        ab_trigger_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            cycle_count_o
);

  localparam int PW = $clog2(RING_LEN);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(RING_LEN - 1);
  localparam logic [DW-1:0] PRE_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUN,
    ST_DRAIN,
    ST_SINGLE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [DW-1:0]    pre_q, pre_d;
  logic             ab_q, ab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cycle_end_q, a_adv_q, b_adv_q;

  logic at_last;
  logic stop_now;
  logic tick;
  logic step_adv;
  logic advance;
  logic wrap;

  assign at_last = (pos_q == POS_LAST);

  // Dropping run exactly on the C1 boundary stops without advancing; this
  // also masks the tick that DIV=1 would otherwise raise in that cycle.
  assign stop_now = (state_q == ST_RUN) && !run_i &&
                    (pos_q == '0) && (pre_q == '0);

  assign tick = (state_q != ST_STOPPED) && (pre_q == PRE_LAST) && !stop_now;

`ifdef IBM_CLOCK_RING_STEP_EN
  // A start request in the same cycle takes precedence over a manual step.
  assign step_adv = (state_q == ST_STOPPED) && step_i && !run_i && !single_cycle_i;
`else
  logic unused_step;
  assign unused_step = step_i;
  assign step_adv    = 1'b0;
`endif

  assign advance = tick || step_adv;
  assign wrap    = advance && at_last;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pre_d   = pre_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_STOPPED: begin
        if (run_i)               state_d = ST_RUN;
        else if (single_cycle_i) state_d = ST_SINGLE;
      end
      ST_RUN: begin
        if (!run_i) begin
          // A wrap in this cycle already lands on the boundary.
          if (stop_now || wrap) state_d = ST_STOPPED;
          else                  state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (run_i)     state_d = ST_RUN;
        else if (wrap) state_d = ST_STOPPED;
      end
      ST_SINGLE: begin
        if (run_i)     state_d = ST_RUN;
        else if (wrap) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase

    // Restart from 0 on entry so the first advance lands DIV edges after start.
    if ((state_q == ST_STOPPED) || (state_d == ST_STOPPED) || tick) pre_d = '0;
    else                                                            pre_d = pre_q + DW'(1);

    if (advance) pos_d = at_last ? '0 : pos_q + PW'(1);

    if (wrap) begin
      ab_d  = ~ab_q;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge SYSCLOCK_i) begin
    if (RESET_i) begin
      state_q     <= ST_STOPPED;
      pos_q       <= '0;
      pre_q       <= '0;
      ab_q        <= 1'b0;
      cnt_q       <= '0;
      cycle_end_q <= 1'b0;
      a_adv_q     <= 1'b0;
      b_adv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pre_q       <= pre_d;
      ab_q        <= ab_d;
      cnt_q       <= cnt_d;
      cycle_end_q <= wrap;
      a_adv_q     <= wrap && !ab_q;
      b_adv_q     <= wrap && ab_q;
    end
  end

  always_comb begin
    ring_o = '0;
    for (int i = 0; i < RING_LEN; i++) ring_o[i] = (pos_q == PW'(i));
  end

  assign pos_o         = pos_q;
  assign tick_o        = tick;
  assign cycle_end_o   = cycle_end_q;
  assign a_advance_o   = a_adv_q;
  assign b_advance_o   = b_adv_q;
  assign ab_trigger_o  = ab_q;
  assign busy_o        = (state_q != ST_STOPPED);
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_ibm_clock_ring_gen.sv
// tb_ibm_clock_ring_gen
//   Directed bench for ibm_clock_ring_gen at RING_LEN=10, DIV=2, CNT_W=16.
//   Inputs change 1 ns after a rising edge and outputs are sampled there too.
//   Optional build macro: IBM_CLOCK_RING_STEP_EN selects the manual-step checks.

module tb_ibm_clock_ring_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        single;
  logic        step;
  logic [9:0]  ring;
  logic [3:0]  pos;
  logic        tick;
  logic        cycle_end;
  logic        a_adv;
  logic        b_adv;
  logic        ab;
  logic        busy;
  logic [15:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ibm_clock_ring_gen #(
    .RING_LEN(10),
    .DIV     (2),
    .CNT_W   (16)
  ) dut (
    .SYSCLOCK_i     (clk),
    .RESET_i        (rst),
    .run_i          (run),
    .single_cycle_i (single),
    .step_i         (step),
    .ring_o         (ring),
    .pos_o          (pos),
    .tick_o         (tick),
    .cycle_end_o    (cycle_end),
    .a_advance_o    (a_adv),
    .b_advance_o    (b_adv),
    .ab_trigger_o   (ab),
    .busy_o         (busy),
    .cycle_count_o  (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n, cend_n, a_n, b_n, tick_n;

    rst = 1'b1; run = 1'b0; single = 1'b0; step = 1'b0;
    clk1; clk1;
    rst = 1'b0;
    repeat (5) clk1;

    // idle after reset
    chk("rst_ring",  32'(ring), 32'h001);
    chk("rst_pos",   32'(pos), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ab",    32'(ab), 0);
    chk("rst_cnt",   32'(cnt), 0);
    chk("rst_pulse", {29'd0, cycle_end, a_adv, b_adv}, 0);
    chk("rst_tick",  32'(tick), 0);

    // free run: edge 0 starts, pos steps every 2 clocks, wraps every 20
    run = 1'b1;
    clk1;
    chk("run_busy0", 32'(busy), 1);
    chk("run_pos0",  32'(pos), 0);
    for (int k = 1; k <= 40; k++) begin
      clk1;
      chk("run_pos",  32'(pos), 32'((k / 2) % 10));
      chk("run_ring", 32'(ring), 32'(1) << ((k / 2) % 10));
      chk("run_tick", 32'(tick), 32'(k % 2));
      chk("run_cend", 32'(cycle_end), 32'(k % 20 == 0));
      chk("run_a",    32'(a_adv), 32'(k == 20));
      chk("run_b",    32'(b_adv), 32'(k == 40));
    end
    chk("run_cnt2", 32'(cnt), 2);
    chk("run_ab",   32'(ab), 0);

    // drop run at pos 4, drain through C10 to a parked C1
    for (int k = 41; k <= 60; k++) begin
      clk1;
      chk("drn_pos",  32'(pos), 32'((k / 2) % 10));
      chk("drn_busy", 32'(busy), 32'(k < 60));
      if (k == 48) run = 1'b0;
    end
    chk("drn_cend", 32'(cycle_end), 1);
    chk("drn_a",    32'(a_adv), 1);
    chk("drn_cnt",  32'(cnt), 3);
    chk("drn_ab",   32'(ab), 1);
    chk("drn_ring", 32'(ring), 32'h001);
    clk1;
    chk("drn_park_pos",  32'(pos), 0);
    chk("drn_park_busy", 32'(busy), 0);
    chk("drn_park_cend", 32'(cycle_end), 0);

    // drain interrupted at pos 7: cadence continues with no stop
    run = 1'b1;
    clk1;
    chk("rer_busy0", 32'(busy), 1);
    for (int k = 1; k <= 40; k++) begin
      clk1;
      if (k < 40) begin
        chk("rer_pos",  32'(pos), 32'((k / 2) % 10));
        chk("rer_busy", 32'(busy), 1);
      end else begin
        chk("rer_stop_pos",  32'(pos), 0);
        chk("rer_stop_busy", 32'(busy), 0);
        chk("rer_stop_a",    32'(a_adv), 1);
      end
      if (k == 20) begin
        chk("rer_cend20", 32'(cycle_end), 1);
        chk("rer_b20",    32'(b_adv), 1);
        chk("rer_a20",    32'(a_adv), 0);
      end
      if (k == 8)  run = 1'b0;
      if (k == 14) run = 1'b1;
      if (k == 24) run = 1'b0;
    end
    chk("rer_cnt", 32'(cnt), 5);
    chk("rer_ab",  32'(ab), 1);

    // run dropped while still on the C1 boundary: stop with no advance
    run = 1'b1;
    clk1;
    chk("imm_busy0", 32'(busy), 1);
    run = 1'b0;
    clk1;
    chk("imm_busy", 32'(busy), 0);
    chk("imm_pos",  32'(pos), 0);
    clk1;
    chk("imm_pos2", 32'(pos), 0);
    chk("imm_cnt",  32'(cnt), 5);

    // single cycle, with a second request mid-cycle that must be ignored
    busy_n = 0; cend_n = 0; a_n = 0; b_n = 0; tick_n = 0;
    single = 1'b1;
    clk1;
    single = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) clk1;
      busy_n += int'(busy);
      cend_n += int'(cycle_end);
      a_n    += int'(a_adv);
      b_n    += int'(b_adv);
      tick_n += int'(tick);
      if (k == 10) single = 1'b1;
      if (k == 11) single = 1'b0;
    end
    chk("sgl_busy_clks", 32'(busy_n), 20);
    chk("sgl_cend_n",    32'(cend_n), 1);
    chk("sgl_a_n",       32'(a_n), 0);
    chk("sgl_b_n",       32'(b_n), 1);
    chk("sgl_tick_n",    32'(tick_n), 10);
    chk("sgl_cnt",       32'(cnt), 6);
    chk("sgl_pos",       32'(pos), 0);

    // reset mid-run at pos 7 with ab_trigger set
    run = 1'b1;
    clk1;
    for (int k = 1; k <= 34; k++) clk1;
    chk("mrs_pre_pos", 32'(pos), 7);
    chk("mrs_pre_ab",  32'(ab), 1);
    chk("mrs_pre_cnt", 32'(cnt), 7);
    rst = 1'b1;
    clk1;
    chk("mrs_pos",  32'(pos), 0);
    chk("mrs_ring", 32'(ring), 32'h001);
    chk("mrs_ab",   32'(ab), 0);
    chk("mrs_busy", 32'(busy), 0);
    chk("mrs_cnt",  32'(cnt), 0);
    rst = 1'b0;
    run = 1'b0;
    clk1;
    chk("mrs_after_busy", 32'(busy), 0);
    chk("mrs_after_pos",  32'(pos), 0);

    // manual step from STOPPED
    a_n = 0; b_n = 0;
    step = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clk1;
`ifdef IBM_CLOCK_RING_STEP_EN
      chk("stp_pos", 32'(pos), 32'(i % 10));
`else
      chk("stp_pos", 32'(pos), 0);
`endif
      chk("stp_busy", 32'(busy), 0);
      a_n += int'(a_adv);
      b_n += int'(b_adv);
    end
    step = 1'b0;
    clk1;
    a_n += int'(a_adv);
    b_n += int'(b_adv);
`ifdef IBM_CLOCK_RING_STEP_EN
    chk("stp_a_n", 32'(a_n), 1);
    chk("stp_cnt", 32'(cnt), 1);
    chk("stp_ab",  32'(ab), 1);
`else
    chk("stp_a_n", 32'(a_n), 0);
    chk("stp_cnt", 32'(cnt), 0);
    chk("stp_ab",  32'(ab), 0);
`endif
    chk("stp_b_n",      32'(b_n), 0);
    chk("stp_end_pos",  32'(pos), 0);
    chk("stp_end_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
